// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the CGRA context-stack program-counter sequencer.
// Latency: n/a (op encodings, entry field layout, width helpers only).
// Backpressure: n/a.
package ctrl_seq_pkg;

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_BRF  = 3'b001;
    localparam logic [2:0] OP_BRT  = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b011;
    localparam logic [2:0] OP_LOOP = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    localparam int OP_W = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Condition-select field is at least one bit, even with a single C-box.
    function automatic int cond_sel_w(input int num_cond);
        return (num_cond <= 1) ? 1 : clog2(num_cond);
    endfunction

    // Entry layout, LSB first: target, csel, op.
    function automatic int target_lsb();
        return 0;
    endfunction

    function automatic int csel_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int op_lsb(input int addr_w, input int csel_w);
        return addr_w + csel_w;
    endfunction

    function automatic int entry_w(input int addr_w, input int csel_w);
        return OP_W + csel_w + addr_w;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control/status bundle between a host and the program-counter sequencer.
// Latency: n/a (wires only). Ports: enable, conditions, memory write, PC load,
// loop set in; PC, done and loop counter out. Backpressure: none (EN_I stalls).
interface control_sequencer_if #(
    parameter int ADDR_W   = 8,
    parameter int NUM_COND = 4,
    parameter int LOOP_W   = 16
);
    import ctrl_seq_pkg::*;

    localparam int COND_SEL_W = cond_sel_w(NUM_COND);
    localparam int ENTRY_W    = entry_w(ADDR_W, COND_SEL_W);

    logic                EN_I;
    logic [NUM_COND-1:0] COND_I;
    logic                WR_EN_I;
    logic [ADDR_W-1:0]   WR_ADDR_I;
    logic [ENTRY_W-1:0]  WR_DATA_I;
    logic                LOAD_EN_I;
    logic [ADDR_W-1:0]   LOAD_ADDR_I;
    logic                LOOP_SET_I;
    logic [LOOP_W-1:0]   LOOP_VAL_I;
    logic [ADDR_W-1:0]   PC_O;
    logic                DONE_O;
    logic [LOOP_W-1:0]   LOOP_CNT_O;

    modport master (
        output EN_I, COND_I, WR_EN_I, WR_ADDR_I, WR_DATA_I,
               LOAD_EN_I, LOAD_ADDR_I, LOOP_SET_I, LOOP_VAL_I,
        input  PC_O, DONE_O, LOOP_CNT_O
    );

    modport slave (
        input  EN_I, COND_I, WR_EN_I, WR_ADDR_I, WR_DATA_I,
               LOAD_EN_I, LOAD_ADDR_I, LOOP_SET_I, LOOP_VAL_I,
        output PC_O, DONE_O, LOOP_CNT_O
    );

endinterface

// File: rtl/ctrl_seq_mem.sv
// Branch-context memory: 2**ADDR_W x DATA_W, one sync write, one async read.
// Latency: read combinational; write visible the cycle after the strobe edge.
// Backpressure: none. Contents are deliberately not reset.
module ctrl_seq_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 13
) (
    input  logic              CLK_I,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK_I) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Async read: a write to the entry currently addressed only takes effect
    // after the edge, so the step decision in that cycle sees the old entry.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/control_sequencer.sv
// Program-counter sequencer for the CGRA context stack: branch/loop/halt ops.
// Latency: PC_O/DONE_O/LOOP_CNT_O registered, change one edge after the decision.
// Backpressure: EN_I=0 stalls the PC; LOAD_EN_I and LOOP_SET_I act regardless.
// Ports: CLK_I, RST_I (async, active-high) and bus (slave side of the bundle).
module control_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int NUM_COND = 4,
    parameter int LOOP_W   = 16
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    control_sequencer_if.slave  bus
);

    localparam int COND_SEL_W = cond_sel_w(NUM_COND);
    localparam int ENTRY_W    = entry_w(ADDR_W, COND_SEL_W);
    localparam int TGT_LSB    = target_lsb();
    localparam int CSEL_LSB   = csel_lsb(ADDR_W);
    localparam int OP_LSB     = op_lsb(ADDR_W, COND_SEL_W);

    logic [ADDR_W-1:0]     pc;
    logic                  done;
    logic [LOOP_W-1:0]     cnt;
    logic [LOOP_W-1:0]     loop_init;

    logic [ENTRY_W-1:0]    entry;
    logic [2:0]            op;
    logic [COND_SEL_W-1:0] csel;
    logic [ADDR_W-1:0]     target;
    logic [ADDR_W-1:0]     pc_inc;
    logic                  c;

    ctrl_seq_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_mem (
        .CLK_I   (CLK_I),
        .wr_en   (bus.WR_EN_I),
        .wr_addr (bus.WR_ADDR_I),
        .wr_data (bus.WR_DATA_I),
        .rd_addr (pc),
        .rd_data (entry)
    );

    assign op     = entry[OP_LSB +: OP_W];
    assign csel   = entry[CSEL_LSB +: COND_SEL_W];
    assign target = entry[TGT_LSB +: ADDR_W];
    assign pc_inc = pc + ADDR_W'(1);

    // Selects that do not name an existing C-box read as false.
    always_comb begin
        c = 1'b0;
        for (int i = 0; i < NUM_COND; i++) begin
            if (csel == COND_SEL_W'(i)) c = bus.COND_I[i];
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            pc        <= '0;
            done      <= 1'b0;
            cnt       <= '0;
            loop_init <= '0;
        end else begin
            if (bus.LOAD_EN_I) begin
                pc   <= bus.LOAD_ADDR_I;
                done <= 1'b0;
            end else if (!done && bus.EN_I) begin
                case (op)
                    OP_BRF:  pc <= c ? pc_inc : target;
                    OP_BRT:  pc <= c ? target : pc_inc;
                    OP_JMP:  pc <= target;
                    OP_LOOP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - LOOP_W'(1);
                            pc  <= target;
                        end else begin
                            cnt <= loop_init;   // re-arm for the next entry
                            pc  <= pc_inc;
                        end
                    end
                    OP_HALT: done <= 1'b1;
                    default: pc <= pc_inc;     // NEXT and reserved ops
                endcase
            end
            // Placed last so it wins over a same-cycle LOOP update of cnt.
            if (bus.LOOP_SET_I) begin
                loop_init <= bus.LOOP_VAL_I;
                cnt       <= bus.LOOP_VAL_I;
            end
        end
    end

    assign bus.PC_O       = pc;
    assign bus.DONE_O     = done;
    assign bus.LOOP_CNT_O = cnt;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer (ADDR_W=8, NUM_COND=4, LOOP_W=16).
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_control_sequencer;
    import ctrl_seq_pkg::*;

    logic CLK_I;
    logic RST_I;

    int vectors;
    int miscompares;

    control_sequencer_if #(.ADDR_W(8), .NUM_COND(4), .LOOP_W(16)) bus ();

    control_sequencer #(.ADDR_W(8), .NUM_COND(4), .LOOP_W(16)) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .bus   (bus)
    );

    initial begin
        CLK_I = 1'b0;
        forever #5 CLK_I = ~CLK_I;
    end

    function automatic logic [12:0] mk(input logic [2:0] op, input logic [1:0] csel,
                                       input logic [7:0] tgt);
        return {op, csel, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk_pc(input string tag, input logic [7:0] exp);
        check(tag, 32'(bus.PC_O), 32'(exp));
    endtask

    // Program mem[5], force pc=5 in the same cycle, then take one step.
    task automatic branch_case(input string tag, input logic [2:0] op,
                               input logic [3:0] cond, input logic [7:0] exp);
        bus.WR_EN_I     = 1'b1;
        bus.WR_ADDR_I   = 8'd5;
        bus.WR_DATA_I   = mk(op, 2'd2, 8'h40);
        bus.LOAD_EN_I   = 1'b1;
        bus.LOAD_ADDR_I = 8'd5;
        tick();
        bus.WR_EN_I   = 1'b0;
        bus.LOAD_EN_I = 1'b0;
        chk_pc({tag, "_load"}, 8'd5);
        bus.COND_I = cond;
        bus.EN_I   = 1'b1;
        tick();
        bus.EN_I = 1'b0;
        chk_pc(tag, exp);
    endtask

    logic [7:0]  loop_pc  [9];
    logic [15:0] loop_cnt [9];

    initial begin
        vectors     = 0;
        miscompares = 0;
        loop_pc  = '{8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4};
        loop_cnt = '{16'd2, 16'd2, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd2};

        RST_I           = 1'b1;
        bus.EN_I        = 1'b0;
        bus.COND_I      = '0;
        bus.WR_EN_I     = 1'b0;
        bus.WR_ADDR_I   = '0;
        bus.WR_DATA_I   = '0;
        bus.LOAD_EN_I   = 1'b0;
        bus.LOAD_ADDR_I = '0;
        bus.LOOP_SET_I  = 1'b0;
        bus.LOOP_VAL_I  = '0;
        #1;
        chk_pc("rst_pc", 8'd0);
        check("rst_done", 32'(bus.DONE_O), 32'd0);
        check("rst_cnt", 32'(bus.LOOP_CNT_O), 32'd0);
        tick();
        RST_I = 1'b0;

        // Fill memory with NEXT while stalled.
        for (int i = 0; i < 256; i++) begin
            bus.WR_EN_I   = 1'b1;
            bus.WR_ADDR_I = 8'(i);
            bus.WR_DATA_I = mk(OP_NEXT, 2'd0, 8'd0);
            tick();
        end
        bus.WR_EN_I = 1'b0;
        chk_pc("stall_fill", 8'd0);

        // Sequential count with wrap.
        bus.EN_I = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            tick();
            chk_pc("count", 8'(k % 256));
            check("count_done", 32'(bus.DONE_O), 32'd0);
        end
        bus.EN_I = 1'b0;

        branch_case("brf_c0",   OP_BRF, 4'b0000, 8'h40);
        branch_case("brf_c1",   OP_BRF, 4'b0100, 8'h06);
        branch_case("brf_oth",  OP_BRF, 4'b1011, 8'h40);
        branch_case("brt_c1",   OP_BRT, 4'b0100, 8'h40);
        branch_case("brt_c0",   OP_BRT, 4'b0000, 8'h06);
        branch_case("brt_oth",  OP_BRT, 4'b1011, 8'h06);
        branch_case("jmp",      OP_JMP, 4'b0000, 8'h40);
        branch_case("rsvd",     3'b110, 4'b1111, 8'h06);
        bus.COND_I = '0;

        // Loop of three iterations: mem[3] = LOOP -> 1, counter preset 2.
        bus.WR_EN_I     = 1'b1;
        bus.WR_ADDR_I   = 8'd3;
        bus.WR_DATA_I   = mk(OP_LOOP, 2'd0, 8'd1);
        bus.LOAD_EN_I   = 1'b1;
        bus.LOAD_ADDR_I = 8'd1;
        bus.LOOP_SET_I  = 1'b1;
        bus.LOOP_VAL_I  = 16'd2;
        tick();
        bus.WR_EN_I    = 1'b0;
        bus.LOAD_EN_I  = 1'b0;
        bus.LOOP_SET_I = 1'b0;
        chk_pc("loop_start", 8'd1);
        check("loop_set", 32'(bus.LOOP_CNT_O), 32'd2);
        bus.EN_I = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk_pc("loop_pc", loop_pc[k]);
            check("loop_cnt", 32'(bus.LOOP_CNT_O), 32'(loop_cnt[k]));
        end
        bus.EN_I = 1'b0;

        // LOOP_SET in the same cycle as a LOOP decrement: set wins, pc still jumps.
        bus.LOAD_EN_I   = 1'b1;
        bus.LOAD_ADDR_I = 8'd3;
        tick();
        bus.LOAD_EN_I  = 1'b0;
        bus.EN_I       = 1'b1;
        bus.LOOP_SET_I = 1'b1;
        bus.LOOP_VAL_I = 16'd7;
        tick();
        bus.EN_I       = 1'b0;
        bus.LOOP_SET_I = 1'b0;
        chk_pc("set_ovr_pc", 8'd1);
        check("set_ovr_cnt", 32'(bus.LOOP_CNT_O), 32'd7);

        // HALT at 7, release by LOAD.
        bus.WR_EN_I     = 1'b1;
        bus.WR_ADDR_I   = 8'd7;
        bus.WR_DATA_I   = mk(OP_HALT, 2'd0, 8'd0);
        bus.LOAD_EN_I   = 1'b1;
        bus.LOAD_ADDR_I = 8'd6;
        tick();
        bus.WR_EN_I   = 1'b0;
        bus.LOAD_EN_I = 1'b0;
        bus.EN_I      = 1'b1;
        tick();
        chk_pc("pre_halt", 8'd7);
        check("pre_halt_done", 32'(bus.DONE_O), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_pc("halt_pc", 8'd7);
            check("halt_done", 32'(bus.DONE_O), 32'd1);
        end
        bus.LOAD_EN_I   = 1'b1;
        bus.LOAD_ADDR_I = 8'h10;
        tick();
        bus.LOAD_EN_I = 1'b0;
        chk_pc("unhalt_pc", 8'h10);
        check("unhalt_done", 32'(bus.DONE_O), 32'd0);
        tick();
        chk_pc("resume", 8'h11);

        // Stall, then load while stalled.
        bus.EN_I = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_pc("stall", 8'h11);
        end
        bus.LOAD_EN_I   = 1'b1;
        bus.LOAD_ADDR_I = 8'h22;
        tick();
        bus.LOAD_EN_I = 1'b0;
        chk_pc("load_stalled", 8'h22);

        // Write to mem[pc] while stepping: old NEXT decides, new JMP next time.
        bus.WR_EN_I   = 1'b1;
        bus.WR_ADDR_I = 8'h22;
        bus.WR_DATA_I = mk(OP_JMP, 2'd0, 8'h50);
        bus.EN_I      = 1'b1;
        tick();
        bus.WR_EN_I = 1'b0;
        bus.EN_I    = 1'b0;
        chk_pc("wr_same_old", 8'h23);
        bus.LOAD_EN_I   = 1'b1;
        bus.LOAD_ADDR_I = 8'h22;
        tick();
        bus.LOAD_EN_I = 1'b0;
        bus.EN_I      = 1'b1;
        tick();
        bus.EN_I = 1'b0;
        chk_pc("wr_same_new", 8'h50);

        // Async reset mid-loop with counter at 5.
        bus.LOOP_SET_I  = 1'b1;
        bus.LOOP_VAL_I  = 16'd5;
        bus.LOAD_EN_I   = 1'b1;
        bus.LOAD_ADDR_I = 8'd1;
        tick();
        bus.LOOP_SET_I = 1'b0;
        bus.LOAD_EN_I  = 1'b0;
        bus.EN_I       = 1'b1;
        tick();
        chk_pc("pre_rst_pc", 8'd2);
        check("pre_rst_cnt", 32'(bus.LOOP_CNT_O), 32'd5);
        #2;
        RST_I = 1'b1;
        #1;
        chk_pc("arst_pc", 8'd0);
        check("arst_cnt", 32'(bus.LOOP_CNT_O), 32'd0);
        check("arst_done", 32'(bus.DONE_O), 32'd0);
        tick();
        chk_pc("rst_hold", 8'd0);
        RST_I    = 1'b0;
        bus.EN_I = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
